program_loader: RTL and testbench

Host-side writer for the CPU instruction memory. It accepts a byte stream from the host input FIFO and parses a load header (start address and word count). It assembles the data bytes into INSTR_LEN-bit instruction words and drives the instruction BRAM's write-only port, which is the counterpart of the fetch unit's read port. Loading happens only while the CPU is held idle; completion and error are reported as status flags to the host.

---
 rtl/program_loader_pkg.sv | 24 ++
 rtl/program_loader_word_assembler.sv | 67 ++++++
 rtl/program_loader.sv | 175 +++++++++++++++++
 tb/tb_program_loader.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// Shared types and defaults for the instruction-memory program loader.
// Optional checksum stage is compiled in with `define PROGRAM_LOADER_CSUM_EN.
package program_loader_pkg;

    localparam int DEF_INSTR_LEN = 16;
    localparam int DEF_IADDR_LEN = 10;

    typedef enum logic [2:0] {
        S_ADDR_LO,
        S_ADDR_HI,
        S_CNT_LO,
        S_CNT_HI,
        S_DATA
`ifdef PROGRAM_LOADER_CSUM_EN
        ,
        S_CSUM
`endif
    } state_e;

    function automatic int bytes_per_word(input int bits);
        return (bits + 7) / 8;
    endfunction

endpackage

// File: rtl/program_loader_word_assembler.sv
// Little-endian byte-to-word assembler: shifts stream bytes in and flags the
// byte that completes a word, presenting the finished word combinationally.
module program_loader_word_assembler
    import program_loader_pkg::*;
#(
    parameter int INSTR_LEN = DEF_INSTR_LEN
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 clr,
    input  logic                 en,
    input  logic [7:0]           din,
    output logic                 word_ready,
    output logic [INSTR_LEN-1:0] word
);

    localparam int BPW = bytes_per_word(INSTR_LEN);
    localparam int SRW = (BPW > 1) ? (BPW - 1) * 8 : 8;
    localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [CW-1:0] LAST = CW'(BPW - 1);

    logic [SRW-1:0]   sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [BPW*8-1:0] full;

    // Only the first BPW-1 bytes need storage; the last one is taken straight from din.
    generate
        if (BPW == 1) begin : g_single
            assign full = din;
        end else begin : g_multi
            assign full = {din, sr_q};
        end
    endgenerate

    assign word = full[INSTR_LEN-1:0];

    always_comb begin
        // NOTE: every signal driven here gets a default first so no latch is inferred.
        sr_d       = sr_q;
        cnt_d      = cnt_q;
        word_ready = 1'b0;
        if (clr) begin
            sr_d  = '0;
            cnt_d = '0;
        end else if (en) begin
            sr_d = full[BPW*8-1 -: SRW];
            if (cnt_q == LAST) begin
                cnt_d      = '0;
                word_ready = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Parses ADDR/CNT headers from the host byte stream and writes assembled
// instruction words into the instruction BRAM; reports loaded/err to the host.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int INSTR_LEN = DEF_INSTR_LEN,
    parameter int IADDR_LEN = DEF_IADDR_LEN
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 load_en,
    input  logic [7:0]           din,
    input  logic                 din_valid,
    output logic                 din_rd,
    output logic                 wr_en,
    output logic [IADDR_LEN-1:0] wr_addr,
    output logic [INSTR_LEN-1:0] wr_data,
    output logic                 busy,
    output logic                 loaded,
    output logic                 err
);

    localparam logic [16:0] ADDR_SPAN = 17'(2 ** IADDR_LEN);

    state_e               state_q, state_d;
    logic [15:0]          start_q, start_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [15:0]          idx_q, idx_d;
    logic [7:0]           csum_q, csum_d;
    logic                 wr_en_q, wr_en_d;
    logic [IADDR_LEN-1:0] wr_addr_q, wr_addr_d;
    logic [INSTR_LEN-1:0] wr_data_q, wr_data_d;
    logic                 busy_q, busy_d;
    logic                 loaded_q, loaded_d;
    logic                 err_q, err_d;

    logic                 asm_clr, asm_en, word_ready;
    logic [INSTR_LEN-1:0] word;
    logic [15:0]          cnt_full;
    logic [16:0]          end_addr;
    logic                 range_err;

    assign din_rd = load_en & din_valid & RESET_N;

    program_loader_word_assembler #(.INSTR_LEN(INSTR_LEN)) u_asm (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .clr        (asm_clr),
        .en         (asm_en),
        .din        (din),
        .word_ready (word_ready),
        .word       (word)
    );

    assign cnt_full  = {din, cnt_q[7:0]};
    assign end_addr  = {1'b0, start_q} + {1'b0, cnt_full};
    assign range_err = ({1'b0, start_q} >= ADDR_SPAN) || (end_addr > ADDR_SPAN);

    always_comb begin
        state_d   = state_q;
        start_d   = start_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        csum_d    = csum_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        busy_d    = busy_q;
        loaded_d  = loaded_q;
        err_d     = err_q;
        asm_clr   = 1'b0;
        asm_en    = 1'b0;
        if (din_rd) begin
            csum_d = csum_q ^ din;
            unique case (state_q)
                S_ADDR_LO: begin
                    start_d  = {start_q[15:8], din};
                    csum_d   = din;
                    busy_d   = 1'b1;
                    loaded_d = 1'b0;
                    err_d    = 1'b0;
                    asm_clr  = 1'b1;
                    state_d  = S_ADDR_HI;
                end
                S_ADDR_HI: begin
                    start_d = {din, start_q[7:0]};
                    state_d = S_CNT_LO;
                end
                S_CNT_LO: begin
                    cnt_d   = {cnt_q[15:8], din};
                    state_d = S_CNT_HI;
                end
                S_CNT_HI: begin
                    cnt_d   = cnt_full;
                    idx_d   = '0;
                    err_d   = range_err;
                    state_d = S_DATA;
                    if (cnt_full == '0) begin
`ifdef PROGRAM_LOADER_CSUM_EN
                        state_d  = S_CSUM;
`else
                        state_d  = S_ADDR_LO;
                        busy_d   = 1'b0;
                        loaded_d = ~range_err;
`endif
                    end
                end
                S_DATA: begin
                    asm_en = 1'b1;
                    if (word_ready) begin
                        // A failed range check keeps the stream framed but never touches memory.
                        wr_en_d   = ~err_q;
                        wr_addr_d = IADDR_LEN'(start_q + idx_q);
                        wr_data_d = word;
                        idx_d     = idx_q + 16'd1;
                        if (idx_q == cnt_q - 16'd1) begin
`ifdef PROGRAM_LOADER_CSUM_EN
                            state_d  = S_CSUM;
`else
                            state_d  = S_ADDR_LO;
                            busy_d   = 1'b0;
                            loaded_d = ~err_q;
`endif
                        end
                    end
                end
`ifdef PROGRAM_LOADER_CSUM_EN
                S_CSUM: begin
                    state_d  = S_ADDR_LO;
                    busy_d   = 1'b0;
                    err_d    = err_q | (din != csum_q);
                    loaded_d = ~err_q & (din == csum_q);
                end
`endif
                default: state_d = S_ADDR_LO;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= S_ADDR_LO;
            start_q   <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            csum_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            loaded_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            start_q   <= start_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            csum_q    <= csum_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            loaded_q  <= loaded_d;
            err_q     <= err_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = busy_q;
    assign loaded  = loaded_q;
    assign err     = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: builds load streams from a word list and predicts
// every write, status flag and stall response from the stream rules.
module tb_program_loader;

    localparam int INSTR_LEN = 16;
    localparam int IADDR_LEN = 10;

    logic                 CLK;
    logic                 RESET_N;
    logic                 load_en;
    logic [7:0]           din;
    logic                 din_valid;
    logic                 din_rd;
    logic                 wr_en;
    logic [IADDR_LEN-1:0] wr_addr;
    logic [INSTR_LEN-1:0] wr_data;
    logic                 busy;
    logic                 loaded;
    logic                 err;

    program_loader #(.INSTR_LEN(INSTR_LEN), .IADDR_LEN(IADDR_LEN)) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .load_en   (load_en),
        .din       (din),
        .din_valid (din_valid),
        .din_rd    (din_rd),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .loaded    (loaded),
        .err       (err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0]  b;
        bit          wr;
        logic [9:0]  a;
        logic [15:0] d;
    } item_t;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] words [0:1023];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_wr_en"},   32'(wr_en),   32'd0);
        chk({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
        chk({tag, "_wr_data"}, 32'(wr_data), 32'd0);
        chk({tag, "_busy"},    32'(busy),    32'd0);
        chk({tag, "_loaded"},  32'(loaded),  32'd0);
        chk({tag, "_err"},     32'(err),     32'd0);
    endtask

    // stall_mode: 0 none, 1 stall before the second byte of every word, 2 random.
    // stop_after >= 0 abandons the stream after that many bytes.
    task automatic do_load(input logic [15:0] start, input logic [15:0] cnt, input bit fixed,
                           input bit bad_csum, input int stall_mode, input int stop_after);
        item_t       q[$];
        item_t       it;
        logic [7:0]  cs;
        logic [15:0] s;
        logic [7:0]  hdr [4];
        bit          range_ok;
        bit          good;
        bit          st;

        range_ok = (int'(start) < 1024) && (int'(start) + int'(cnt) <= 1024);
        hdr[0] = start[7:0];
        hdr[1] = start[15:8];
        hdr[2] = cnt[7:0];
        hdr[3] = cnt[15:8];
        cs = 8'h00;
        for (int i = 0; i < 4; i++) begin
            it = '{b: hdr[i], wr: 1'b0, a: '0, d: '0};
            q.push_back(it);
            cs ^= hdr[i];
        end
        for (int i = 0; i < int'(cnt); i++) begin
            if (!fixed) words[i] = 16'($urandom);
            s = start + 16'(i);
            it = '{b: words[i][7:0], wr: 1'b0, a: '0, d: '0};
            q.push_back(it);
            it = '{b: words[i][15:8], wr: range_ok, a: s[9:0], d: words[i]};
            q.push_back(it);
            cs ^= words[i][7:0] ^ words[i][15:8];
        end
        good = range_ok;
`ifdef PROGRAM_LOADER_CSUM_EN
        it = '{b: cs ^ {7'd0, bad_csum}, wr: 1'b0, a: '0, d: '0};
        q.push_back(it);
        good = range_ok && !bad_csum;
`endif

        for (int k = 0; k < q.size(); k++) begin
            if (stop_after >= 0 && k == stop_after) return;
            st = (stall_mode == 1 && k >= 4 && ((k - 4) % 2 == 1)) ||
                 (stall_mode == 2 && $urandom_range(0, 3) == 0);
            if (st) begin
                load_en   = 1'b0;
                din_valid = 1'b1;
                din       = q[k].b;
                #1 chk("din_rd_stalled", 32'(din_rd), 32'd0);
                @(negedge CLK);
                chk("wr_en_stalled", 32'(wr_en), 32'd0);
            end
            load_en   = 1'b1;
            din_valid = 1'b1;
            din       = q[k].b;
            #1 chk("din_rd", 32'(din_rd), 32'd1);
            @(negedge CLK);
            din_valid = 1'b0;
            chk("wr_en", 32'(wr_en), 32'(q[k].wr));
            if (q[k].wr) begin
                chk("wr_addr", 32'(wr_addr), 32'(q[k].a));
                chk("wr_data", 32'(wr_data), 32'(q[k].d));
            end
            if (k == 0) begin
                chk("busy_hdr", 32'(busy), 32'd1);
                chk("loaded_hdr", 32'(loaded), 32'd0);
                chk("err_hdr", 32'(err), 32'd0);
            end
            if (k == 3) chk("err_range", 32'(err), 32'(!range_ok));
        end
        chk("busy_done", 32'(busy), 32'd0);
        chk("loaded_done", 32'(loaded), 32'(good));
        chk("err_done", 32'(err), 32'(!good));
        @(negedge CLK);
        chk("wr_en_idle", 32'(wr_en), 32'd0);
        chk("loaded_hold", 32'(loaded), 32'(good));
    endtask

    initial begin
        logic [15:0] st_addr;
        logic [15:0] st_cnt;
        int          sel;

        RESET_N   = 1'b0;
        load_en   = 1'b0;
        din_valid = 1'b0;
        din       = 8'h00;
        repeat (2) @(negedge CLK);
        chk_reset_vals("reset");
        RESET_N = 1'b1;
        @(negedge CLK);
        chk_reset_vals("post_reset");
        #1 chk("din_rd_idle", 32'(din_rd), 32'd0);

        // Basic three-word load at address 0.
        words[0] = 16'h1234;
        words[1] = 16'h5678;
        words[2] = 16'h9ABC;
        do_load(16'h0000, 16'd3, 1'b1, 1'b0, 0, -1);

        // Range overflow: data consumed, no writes, err raised.
        do_load(16'h03FE, 16'd3, 1'b0, 1'b0, 0, -1);
        // Start address itself beyond the memory.
        do_load(16'h8000, 16'd1, 1'b0, 1'b0, 0, -1);
        // Empty load.
        do_load(16'h0010, 16'd0, 1'b0, 1'b0, 0, -1);
        // load_en dropped mid-word.
        do_load(16'h0123, 16'd4, 1'b0, 1'b0, 1, -1);
        // Bad checksum then a clean load (bad_csum is ignored without the checksum stage).
        do_load(16'h0200, 16'd2, 1'b0, 1'b1, 0, -1);
        do_load(16'h0300, 16'd2, 1'b0, 1'b0, 0, -1);
        // Exactly reaching the top of memory.
        do_load(16'h03FC, 16'd4, 1'b0, 1'b0, 0, -1);

        // Reset in the middle of a word inside S_DATA.
        do_load(16'h0100, 16'd4, 1'b0, 1'b0, 0, 7);
        RESET_N   = 1'b0;
        load_en   = 1'b1;
        din_valid = 1'b1;
        #1;
        chk_reset_vals("mid_reset");
        chk("din_rd_in_reset", 32'(din_rd), 32'd0);
        @(negedge CLK);
        din_valid = 1'b0;
        RESET_N   = 1'b1;
        @(negedge CLK);
        do_load(16'h0100, 16'd4, 1'b0, 1'b0, 0, -1);

        // Randomized loads with random stalls.
        for (int r = 0; r < 8; r++) begin
            sel = int'($urandom_range(0, 3));
            case (sel)
                0:       st_addr = 16'($urandom_range(0, 1023));
                1:       st_addr = 16'($urandom_range(1018, 1023));
                2:       st_addr = 16'($urandom_range(1024, 65535));
                default: st_addr = 16'($urandom_range(0, 64));
            endcase
            st_cnt = 16'($urandom_range(0, 7));
            do_load(st_addr, st_cnt, 1'b0, 1'($urandom_range(0, 1)), 2, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
